// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among byte producers.
// Packets hold the transmitter until Last or until the hold timer expires.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                         Clock,
    input  logic                         ResetN,
    input  logic [NUM_REQ-1:0]           ReqValid,
    input  logic [NUM_REQ*DATA_BITS-1:0] ReqData,
    input  logic [NUM_REQ-1:0]           ReqLast,
    output logic [NUM_REQ-1:0]           ReqReady,
    output logic                         TxStart,
    output logic [DATA_BITS-1:0]         DataOut,
    input  logic                         TxReady,
    output logic [NUM_REQ-1:0]           Grant,
    output logic                         Busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;

    typedef enum logic [1:0] {ARB, START, WAIT, HOLD} state_t;

    state_t          state;
    state_t          stateNext;
    logic [PW-1:0]   pointer;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   winIdx;
    logic [PW-1:0]   scanIdx;
    logic [PW-1:0]   acceptIdx;
    logic            winFound;
    logic            accept;
    logic            unlock;
    logic            timerClr;
    logic            timerInc;
    logic            lastReg;
    logic [TW-1:0]   holdTimer;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        scanIdx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = PW'((int'(pointer) + k) % NUM_REQ);
            if (!winFound && ReqValid[scanIdx]) begin
                winFound = 1'b1;
                winIdx   = scanIdx;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state <= ARB;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        acceptIdx = owner;
        unlock    = 1'b0;
        timerClr  = 1'b0;
        timerInc  = 1'b0;
        unique case (state)
            ARB: begin
                if (winFound) begin
                    accept    = 1'b1;
                    acceptIdx = winIdx;
                    stateNext = START;
                end
            end
            START: stateNext = WAIT;
            WAIT: begin
                if (TxReady) begin
                    if (lastReg) begin
                        unlock    = 1'b1;
                        stateNext = ARB;
                    end else begin
                        timerClr  = 1'b1;
                        stateNext = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ReqValid[owner]) begin
                    accept    = 1'b1;
                    timerClr  = 1'b1;
                    stateNext = START;
                end else if (holdTimer == TW'(HOLD_TIMEOUT - 1)) begin
                    unlock    = 1'b1;
                    stateNext = ARB;
                end else begin
                    timerInc  = 1'b1;
                end
            end
            default: stateNext = ARB;
        endcase
    end

    always_comb begin
        ReqReady = '0;
        if (accept && ResetN) begin
            ReqReady[acceptIdx] = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            pointer   <= '0;
            owner     <= '0;
            Grant     <= '0;
            DataOut   <= '0;
            lastReg   <= 1'b0;
            holdTimer <= '0;
        end else begin
            if (accept) begin
                DataOut <= ReqData[acceptIdx*DATA_BITS +: DATA_BITS];
                lastReg <= ReqLast[acceptIdx];
                owner   <= acceptIdx;
                Grant   <= NUM_REQ'(1) << acceptIdx;
            end
            if (unlock) begin
                pointer <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                Grant   <= '0;
            end
            if (timerClr) begin
                holdTimer <= '0;
            end else if (timerInc) begin
                holdTimer <= holdTimer + 1'b1;
            end
        end
    end

    assign TxStart = (state == START);
    assign Busy    = (state != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requesters, a transmitter
// model, and a monitor that pops expected bytes on every TxStart.
module tb_uart_tx_arbiter;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic [3:0]  ReqValid;
    logic [31:0] ReqData;
    logic [3:0]  ReqLast;
    logic [3:0]  ReqReady;
    logic        TxStart;
    logic [7:0]  DataOut;
    logic        TxReady;
    logic [3:0]  Grant;
    logic        Busy;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_BITS(8),
        .HOLD_TIMEOUT(16)
    ) dut (
        .Clock(Clock),
        .ResetN(ResetN),
        .ReqValid(ReqValid),
        .ReqData(ReqData),
        .ReqLast(ReqLast),
        .ReqReady(ReqReady),
        .TxStart(TxStart),
        .DataOut(DataOut),
        .TxReady(TxReady),
        .Grant(Grant),
        .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] d;
        logic [3:0] g;
    } exp_t;

    exp_t       expQ[$];
    logic [8:0] rq[4][$];
    logic [3:0] acc = '0;
    int         checks = 0;
    int         passes = 0;
    int         txStarts = 0;
    int         txReadies = 0;
    logic       txAuto = 1'b1;
    logic       txForce = 1'b0;
    logic       txPending = 1'b0;
    logic       prevTx = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic expect_tx(input logic [7:0] d, input logic [3:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        expQ.push_back(e);
    endtask

    // Requesters: present queue heads, pop on a sampled handshake.
    always @(negedge Clock) acc = ReqValid & ReqReady;

    initial begin
        logic [8:0] e;
        ReqValid = '0;
        ReqData  = '0;
        ReqLast  = '0;
        forever begin
            @(posedge Clock);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    e = rq[i][0];
                    ReqValid[i]       = 1'b1;
                    ReqData[i*8 +: 8] = e[7:0];
                    ReqLast[i]        = e[8];
                end else begin
                    ReqValid[i]       = 1'b0;
                    ReqData[i*8 +: 8] = '0;
                    ReqLast[i]        = 1'b0;
                end
            end
        end
    end

    // Transmitter: TxReady pulse a few cycles after each TxStart.
    initial begin
        int  cnt;
        logic gen;
        cnt = 0;
        TxReady = 1'b0;
        forever begin
            @(posedge Clock);
            #3;
            gen = 1'b0;
            if (!ResetN) begin
                txPending = 1'b0;
            end else if (txPending) begin
                if (cnt == 0) begin
                    gen = 1'b1;
                    txPending = 1'b0;
                    txReadies++;
                end else begin
                    cnt--;
                end
            end else if (txAuto && TxStart) begin
                txPending = 1'b1;
                cnt = 2;
            end
            TxReady = gen | txForce;
        end
    end

    always @(negedge Clock) begin
        exp_t e;
        if (TxStart) begin
            txStarts++;
            check("txstart_pulse_width", 32'(prevTx), 0);
            if (expQ.size() == 0) begin
                check("unexpected_txstart", 32'(TxStart), 0);
            end else begin
                e = expQ.pop_front();
                check("txstart_data", 32'(DataOut), 32'(e.d));
                check("txstart_grant", 32'(Grant), 32'(e.g));
            end
        end
        prevTx = TxStart;
    end

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((expQ.size() != 0 || Busy || txPending) && n < bound) begin
            @(negedge Clock);
            n++;
        end
        check("idle_reached", 32'(n < bound), 1);
    endtask

    task automatic wait_txready(input int bound);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!TxReady && n < bound);
        check("txready_seen", 32'(TxReady), 1);
    endtask

    task automatic wait_grant(input logic [3:0] g, input int bound);
        int n = 0;
        while (Grant !== g && n < bound) begin
            @(negedge Clock);
            n++;
        end
        check("grant_reached", 32'(Grant), 32'(g));
    endtask

    task automatic do_reset();
        @(negedge Clock);
        ResetN = 1'b0;
        for (int i = 0; i < 4; i++) rq[i].delete();
        @(negedge Clock);
        ResetN = 1'b1;
    endtask

    initial begin
        int n;
        int s0;
        int r0;
        ResetN = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_grant", 32'(Grant), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_txstart", 32'(TxStart), 0);
        check("rst_dataout", 32'(DataOut), 0);
        check("rst_reqready", 32'(ReqReady), 0);
        ResetN = 1'b1;

        // Single byte
        @(negedge Clock);
        rq[2].push_back({1'b1, 8'hA5});
        expect_tx(8'hA5, 4'b0100);
        @(posedge Clock);
        #2;
        check("single_ready", 32'(ReqReady), 'h4);
        @(posedge Clock);
        #2;
        check("single_ready_drop", 32'(ReqReady), 0);
        check("single_grant", 32'(Grant), 'h4);
        wait_txready(30);
        @(negedge Clock);
        check("single_release_grant", 32'(Grant), 0);
        check("single_release_busy", 32'(Busy), 0);
        wait_idle(30);

        // Round robin over four requesters
        do_reset();
        s0 = txStarts;
        r0 = txReadies;
        rq[0].push_back({1'b1, 8'h10});
        rq[0].push_back({1'b1, 8'h10});
        rq[1].push_back({1'b1, 8'h11});
        rq[2].push_back({1'b1, 8'h12});
        rq[3].push_back({1'b1, 8'h13});
        expect_tx(8'h10, 4'b0001);
        expect_tx(8'h11, 4'b0010);
        expect_tx(8'h12, 4'b0100);
        expect_tx(8'h13, 4'b1000);
        expect_tx(8'h10, 4'b0001);
        wait_idle(300);
        check("rr_txstarts", 32'(txStarts - s0), 5);
        check("rr_txreadies", 32'(txReadies - r0), 5);

        // Packet lock with competing requesters
        do_reset();
        rq[1].push_back({1'b0, 8'h01});
        rq[1].push_back({1'b0, 8'h02});
        rq[1].push_back({1'b1, 8'h03});
        expect_tx(8'h01, 4'b0010);
        expect_tx(8'h02, 4'b0010);
        expect_tx(8'h03, 4'b0010);
        expect_tx(8'hB3, 4'b1000);
        expect_tx(8'hA0, 4'b0001);
        wait_grant(4'b0010, 20);
        rq[0].push_back({1'b1, 8'hA0});
        rq[3].push_back({1'b1, 8'hB3});
        wait_idle(300);

        // Hold timeout
        do_reset();
        rq[0].push_back({1'b0, 8'hC0});
        rq[2].push_back({1'b1, 8'hC2});
        expect_tx(8'hC0, 4'b0001);
        expect_tx(8'hC2, 4'b0100);
        wait_txready(30);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (Grant != 4'b0000 && n < 40);
        check("timeout_cycles", 32'(n), 17);
        check("timeout_busy", 32'(Busy), 0);
        check("timeout_next_ready", 32'(ReqReady), 'h4);
        wait_idle(100);

        // Spurious TxReady in ARB
        do_reset();
        s0 = txStarts;
        @(negedge Clock);
        txForce = 1'b1;
        @(negedge Clock);
        txForce = 1'b0;
        repeat (3) @(negedge Clock);
        check("spur_arb_busy", 32'(Busy), 0);
        check("spur_arb_txstarts", 32'(txStarts - s0), 0);

        // Spurious TxReady in HOLD
        rq[0].push_back({1'b0, 8'hC5});
        expect_tx(8'hC5, 4'b0001);
        wait_txready(30);
        repeat (3) @(negedge Clock);
        txForce = 1'b1;
        @(negedge Clock);
        txForce = 1'b0;
        repeat (2) @(negedge Clock);
        check("spur_hold_busy", 32'(Busy), 1);
        check("spur_hold_grant", 32'(Grant), 'h1);
        wait_idle(60);
        check("spur_hold_txstarts", 32'(txStarts - s0), 1);

        // No TxReady in WAIT
        txAuto = 1'b0;
        rq[1].push_back({1'b1, 8'hC6});
        expect_tx(8'hC6, 4'b0010);
        repeat (40) @(negedge Clock);
        check("wait_busy", 32'(Busy), 1);
        check("wait_grant", 32'(Grant), 'h2);
        check("wait_txstarts", 32'(txStarts - s0), 2);
        txForce = 1'b1;
        @(negedge Clock);
        txForce = 1'b0;
        txAuto = 1'b1;
        @(negedge Clock);
        check("wait_released", 32'(Busy), 0);

        // Reset in HOLD after a pointer advance
        do_reset();
        rq[1].push_back({1'b1, 8'hD1});
        rq[2].push_back({1'b0, 8'hD2});
        expect_tx(8'hD1, 4'b0010);
        expect_tx(8'hD2, 4'b0100);
        wait_grant(4'b0100, 40);
        wait_txready(30);
        repeat (2) @(negedge Clock);
        check("midrst_queue", 32'(expQ.size()), 0);
        check("midrst_busy_before", 32'(Busy), 1);
        do_reset();
        check("midrst_grant", 32'(Grant), 0);
        check("midrst_busy", 32'(Busy), 0);
        check("midrst_txstart", 32'(TxStart), 0);
        rq[0].push_back({1'b1, 8'hE0});
        rq[3].push_back({1'b1, 8'hE3});
        expect_tx(8'hE0, 4'b0001);
        expect_tx(8'hE3, 4'b1000);
        wait_idle(100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
